fg_fetch_responder: RTL

Responder end of the pipeline's foreground fetch interface. Accepts one foreground pixel request per cycle (signed x/y plus active flag), rejects out-of-frame coordinates, issues the read to the foreground SRAM port, and returns pixel or skip on a fully pipelined path. Every request gets exactly one response, exactly FETCH_DELAY cycles after it is sampled. It sits between the compositing pipeline and the foreground frame-buffer SRAM arbiter.

---
 rtl/fg_fetch_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fg_fetch_responder.sv
// Foreground fetch responder: bounds-checks signed pixel requests, issues SRAM reads, returns pixel or skip in order.
// Latency: exactly FETCH_DELAY cycles from request sample to fg_pixel_ready; fully pipelined, one request per cycle.
// Backpressure: none; a denied SRAM read becomes a skip response. Optional miss counter under FG_FETCH_MISS_COUNTER_EN.
module fg_fetch_responder #(
    parameter int PRECISION    = 12,
    parameter int RESOLUTION_X = 1920,
    parameter int RESOLUTION_Y = 1080,
    parameter int ADDR_WIDTH   = 21,
    parameter int SRAM_LATENCY = 2,
    parameter int FETCH_DELAY  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRECISION:0]    fg_pixel_request_x,
    input  logic [PRECISION:0]    fg_pixel_request_y,
    input  logic                  fg_pixel_request_active,
    input  logic [ADDR_WIDTH-1:0] fb_base_addr,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_read_en,
    input  logic                  sram_grant,
    input  logic [15:0]           sram_rdata,
    output logic [15:0]           fg_pixel_in,
    output logic                  fg_pixel_skip,
    output logic                  fg_pixel_ready
`ifdef FG_FETCH_MISS_COUNTER_EN
    ,
    output logic [15:0]           miss_count,
    input  logic                  miss_count_clear
`endif
);

    localparam int TAG_LEN  = FETCH_DELAY - 2;
    localparam int DATA_DLY = FETCH_DELAY - SRAM_LATENCY - 2;

    generate
        if (FETCH_DELAY < SRAM_LATENCY + 2) begin : g_bad_delay
            $error("fg_fetch_responder: FETCH_DELAY must be >= SRAM_LATENCY+2");
        end
    endgenerate

    typedef struct packed {
        logic vld;
        logic skip;
    } tag_t;

    int                  x_i;
    int                  y_i;
    logic                in_frame;
    logic [ADDR_WIDTH-1:0] req_addr;

    always_comb begin
        x_i      = int'($signed(fg_pixel_request_x));
        y_i      = int'($signed(fg_pixel_request_y));
        in_frame = (x_i >= 0) && (x_i < RESOLUTION_X) && (y_i >= 0) && (y_i < RESOLUTION_Y);
        // Only meaningful when in_frame, so the unsigned low bits are the coordinate.
        req_addr = ADDR_WIDTH'(fg_pixel_request_y[PRECISION-1:0]) * ADDR_WIDTH'(RESOLUTION_X)
                 + ADDR_WIDTH'(fg_pixel_request_x[PRECISION-1:0]) + fb_base_addr;
    end

    logic s1_vld;
    tag_t tag_q [1:TAG_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld       <= 1'b0;
            sram_read_en <= 1'b0;
            sram_addr    <= '0;
            for (int k = 1; k <= TAG_LEN; k++) tag_q[k] <= '0;
        end else begin
            s1_vld       <= fg_pixel_request_active;
            sram_read_en <= fg_pixel_request_active && in_frame;
            if (fg_pixel_request_active && in_frame) sram_addr <= req_addr;
            // Denied reads are never retried; the grant is judged only in the strobe cycle.
            tag_q[1].vld  <= s1_vld;
            tag_q[1].skip <= s1_vld && (!sram_read_en || !sram_grant);
            for (int k = 2; k <= TAG_LEN; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    logic [15:0] data_last;

    generate
        if (DATA_DLY == 0) begin : g_no_dly
            assign data_last = sram_rdata;
        end else begin : g_dly
            logic [15:0] data_q [DATA_DLY];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DATA_DLY; k++) data_q[k] <= '0;
                end else begin
                    data_q[0] <= sram_rdata;
                    for (int k = 1; k < DATA_DLY; k++) data_q[k] <= data_q[k-1];
                end
            end
            assign data_last = data_q[DATA_DLY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg_pixel_ready <= 1'b0;
            fg_pixel_skip  <= 1'b0;
            fg_pixel_in    <= '0;
        end else begin
            fg_pixel_ready <= tag_q[TAG_LEN].vld;
            fg_pixel_skip  <= tag_q[TAG_LEN].vld && tag_q[TAG_LEN].skip;
            fg_pixel_in    <= (tag_q[TAG_LEN].vld && !tag_q[TAG_LEN].skip) ? data_last : 16'd0;
        end
    end

`ifdef FG_FETCH_MISS_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= '0;
        end else if (miss_count_clear) begin
            miss_count <= '0;
        end else if (sram_read_en && !sram_grant && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
